// File: rtl/oserdes_word_scheduler.sv
// Round-robin burst scheduler feeding the shared OSERDES2 parallel word input.
// Bursts are framed by a sync pulse and separated by a fixed idle guard gap.
module oserdes_word_scheduler #(
  parameter int WIDTH = 8,
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_BURST_LENGTH = 16,
  parameter int LW = $clog2(MAX_BURST_LENGTH + 1),
  parameter int GAP_WORDS = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'b00000000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_REQUESTERS-1:0]       request,
  input  logic [NUM_REQUESTERS*LW-1:0]    request_length,
  input  logic [NUM_REQUESTERS*WIDTH-1:0] request_word,
  output logic [NUM_REQUESTERS-1:0]       grant,
  output logic [NUM_REQUESTERS-1:0]       taken,
  output logic [WIDTH-1:0]                word_out,
  output logic                            sync,
  output logic                            busy,
  output logic                            abort
);

  localparam int PW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_POST = (GAP_WORDS == 0) ? ST_IDLE : ST_GAP;
  localparam logic [3:0] GAP_INIT = (GAP_WORDS > 0) ? 4'(GAP_WORDS - 1) : 4'd0;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [LW-1:0]    remaining;
  logic [3:0]       gap_cnt;
  logic             first;

  logic             found;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    next_ptr;
  logic [LW-1:0]    raw_len;
  logic [LW-1:0]    win_len;
  logic             owner_req;
  logic [WIDTH-1:0] owner_word;

  // Round-robin search starting at ptr, wrapping around the requester set.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = ptr;
    idx    = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_REQUESTERS;
      if (!found && request[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Zero-length requests still send one word; oversize requests are clamped.
  always_comb begin
    raw_len = request_length[int'(winner)*LW +: LW];
    if (raw_len == LW'(0)) begin
      win_len = LW'(1);
    end else if (raw_len > LW'(MAX_BURST_LENGTH)) begin
      win_len = LW'(MAX_BURST_LENGTH);
    end else begin
      win_len = raw_len;
    end
  end

  assign next_ptr   = (winner == PW'(NUM_REQUESTERS - 1)) ? PW'(0) : winner + PW'(1);
  assign owner_req  = request[owner];
  assign owner_word = request_word[int'(owner)*WIDTH +: WIDTH];
  assign taken      = (state == ST_SEND) ? (grant & request) : '0;
  assign busy       = (state == ST_SEND) || (state == ST_GAP);

  // Burst state machine; word_out, sync and abort are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      remaining <= '0;
      gap_cnt   <= 4'd0;
      first     <= 1'b0;
      grant     <= '0;
      word_out  <= IDLE_WORD;
      sync      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      word_out <= IDLE_WORD;
      sync     <= 1'b0;
      abort    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && found) begin
            grant     <= NUM_REQUESTERS'(1) << winner;
            owner     <= winner;
            ptr       <= next_ptr;
            remaining <= win_len - LW'(1);
            first     <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          first <= 1'b0;
          // A dropped request cuts the burst: this cycle's word is discarded.
          if (!owner_req) begin
            abort   <= 1'b1;
            grant   <= '0;
            gap_cnt <= GAP_INIT;
            state   <= ST_POST;
          end else begin
            word_out <= owner_word;
            sync     <= first;
            if (remaining == LW'(0)) begin
              grant   <= '0;
              gap_cnt <= GAP_INIT;
              state   <= ST_POST;
            end else begin
              remaining <= remaining - LW'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oserdes_word_scheduler.sv
// Directed bench for oserdes_word_scheduler: timing, round robin, clamping,
// abort, enable gating and mid-burst reset.
module tb_oserdes_word_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int LW = 5;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic [N-1:0] request;
  logic [N*LW-1:0] request_length;
  logic [N*W-1:0] request_word;
  logic [N-1:0] grant;
  logic [N-1:0] taken;
  logic [W-1:0] word_out;
  logic sync;
  logic busy;
  logic abort;

  int checks = 0;
  int errors = 0;
  int feed_idx [N];
  logic [7:0] base [N];

  oserdes_word_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .request(request),
    .request_length(request_length), .request_word(request_word),
    .grant(grant), .taken(taken), .word_out(word_out), .sync(sync),
    .busy(busy), .abort(abort)
  );

  always #5 clock = ~clock;

  task automatic update_words();
    for (int i = 0; i < N; i++) request_word[i*W +: W] = base[i] + 8'(feed_idx[i]);
  endtask

  // A requester advances its word after every cycle in which it was taken.
  task automatic tick();
    logic [N-1:0] tk;
    tk = taken;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (tk[i]) feed_idx[i]++;
    update_words();
  endtask

  task automatic set_len(input int idx, input int len);
    request_length[idx*LW +: LW] = LW'(len);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    request = '0;
    for (int i = 0; i < N; i++) feed_idx[i] = 0;
    update_words();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_burst(input int req, input int len, input int drop_after, input int cycles,
                           output int n_taken, output int n_words, output int n_sync,
                           output int n_abort, output int n_busy, output logic [7:0] last_word);
    n_taken = 0; n_words = 0; n_sync = 0; n_abort = 0; n_busy = 0; last_word = 8'h00;
    for (int i = 0; i < N; i++) feed_idx[i] = 0;
    update_words();
    set_len(req, len);
    request = '0;
    request[req] = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (drop_after > 0 && n_taken >= drop_after) request[req] = 1'b0;
      if (busy && grant == '0) request[req] = 1'b0;
      #1;
      if (taken[req]) n_taken++;
      if (word_out !== 8'h00) begin n_words++; last_word = word_out; end
      if (sync) n_sync++;
      if (abort) n_abort++;
      if (busy) n_busy++;
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (taken !== 4'b0000) begin errors++; $display("FAIL reset_taken: got %b expected 0000", taken); end
    checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word: got %h expected 00", word_out); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b expected 0", sync); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort); end
  endtask

  task automatic test_single_burst();
    logic [7:0] exp_w [9] = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00};
    logic [8:0] exp_taken = 9'b000011110;
    logic [8:0] exp_sync  = 9'b000000100;
    logic [8:0] exp_busy  = 9'b001111110;
    apply_reset();
    enable = 1'b1;
    set_len(0, 4);
    request = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) request = 4'b0000;
      #1;
      checks++; if (word_out !== exp_w[c]) begin errors++; $display("FAIL single_word c%0d: got %h expected %h", c, word_out, exp_w[c]); end
      checks++; if (taken[0] !== exp_taken[c]) begin errors++; $display("FAIL single_taken c%0d: got %b expected %b", c, taken[0], exp_taken[c]); end
      checks++; if (sync !== exp_sync[c]) begin errors++; $display("FAIL single_sync c%0d: got %b expected %b", c, sync, exp_sync[c]); end
      checks++; if (busy !== exp_busy[c]) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, exp_busy[c]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seen [3] = '{4'b0000, 4'b0000, 4'b0000};
    int nseen = 0;
    apply_reset();
    enable = 1'b1;
    set_len(1, 1);
    set_len(3, 1);
    request = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (grant != 4'b0000 && nseen < 3) begin seen[nseen] = grant; nseen++; end
      tick();
    end
    request = 4'b0000;
    checks++; if (nseen !== 3) begin errors++; $display("FAIL rr_count: got %0d expected 3", nseen); end
    checks++; if (seen[0] !== 4'b0010) begin errors++; $display("FAIL rr_first: got %b expected 0010", seen[0]); end
    checks++; if (seen[1] !== 4'b1000) begin errors++; $display("FAIL rr_second: got %b expected 1000", seen[1]); end
    checks++; if (seen[2] !== 4'b0010) begin errors++; $display("FAIL rr_wrap: got %b expected 0010", seen[2]); end
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_length_limits();
    int nt, nw, ns, na, nb;
    logic [7:0] lw;
    apply_reset();
    enable = 1'b1;
    run_burst(0, 0, 0, 12, nt, nw, ns, na, nb, lw);
    checks++; if (nt !== 1) begin errors++; $display("FAIL len0_taken: got %0d expected 1", nt); end
    checks++; if (nw !== 1) begin errors++; $display("FAIL len0_words: got %0d expected 1", nw); end
    checks++; if (nb !== 3) begin errors++; $display("FAIL len0_busy: got %0d expected 3", nb); end
    checks++; if (lw !== 8'hA1) begin errors++; $display("FAIL len0_word: got %h expected a1", lw); end
    run_burst(0, 31, 0, 30, nt, nw, ns, na, nb, lw);
    checks++; if (nt !== 16) begin errors++; $display("FAIL clamp_taken: got %0d expected 16", nt); end
    checks++; if (nw !== 16) begin errors++; $display("FAIL clamp_words: got %0d expected 16", nw); end
    checks++; if (ns !== 1) begin errors++; $display("FAIL clamp_sync: got %0d expected 1", ns); end
    checks++; if (lw !== 8'hB0) begin errors++; $display("FAIL clamp_last: got %h expected b0", lw); end
  endtask

  task automatic test_abort();
    int nt, nw, ns, na, nb;
    logic [7:0] lw;
    apply_reset();
    enable = 1'b1;
    run_burst(2, 5, 2, 14, nt, nw, ns, na, nb, lw);
    #1;
    checks++; if (nt !== 2) begin errors++; $display("FAIL abort_taken: got %0d expected 2", nt); end
    checks++; if (nw !== 2) begin errors++; $display("FAIL abort_words: got %0d expected 2", nw); end
    checks++; if (na !== 1) begin errors++; $display("FAIL abort_pulses: got %0d expected 1", na); end
    checks++; if (nb !== 5) begin errors++; $display("FAIL abort_busy: got %0d expected 5", nb); end
    checks++; if (lw !== 8'hC2) begin errors++; $display("FAIL abort_last: got %h expected c2", lw); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant: got %b expected 0000", grant); end
  endtask

  task automatic test_enable();
    apply_reset();
    enable = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 1);
    request = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy c%0d: got %b expected 0", c, busy); end
      checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL en_word c%0d: got %h expected 00", c, word_out); end
      tick();
    end
    enable = 1'b1;
    tick();
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL en_grant: got %b expected 0001", grant); end
    tick();
    request = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    enable = 1'b1;
    set_len(1, 5);
    request = 4'b0010;
    for (int c = 0; c < 4; c++) begin #1; tick(); end
    #1;
    checks++; if (word_out !== 8'hB3) begin errors++; $display("FAIL mid_third: got %h expected b3", word_out); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request = 4'b1111;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant: got %b expected 0000", grant); end
    checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL mid_word: got %h expected 00", word_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL mid_sync: got %b expected 0", sync); end
    tick();
    #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_next: got %b expected 0001", grant); end
    tick();
    request = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    request = '0;
    request_length = '0;
    request_word = '0;
    base[0] = 8'hA1; base[1] = 8'hB1; base[2] = 8'hC1; base[3] = 8'hD1;
    for (int i = 0; i < N; i++) feed_idx[i] = 0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_length_limits();
    test_abort();
    test_enable();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oserdes_word_scheduler.md
# oserdes_word_scheduler

Arbitrates between several requesters that each want to send a burst of parallel words through the shared 8-bit OSERDES2 master/slave trigger serializer. It sits in the word-clock domain, the divided clock from oserdes_pll, and drives the serializer's parallel word input. Only one requester's burst reaches the line at a time. Bursts are separated by a fixed idle guard gap so that downstream receivers can frame them.

## Interface
- WIDTH, 8, serializer word width in bits.
- NUM_REQUESTERS, 4, number of requesters (2..8).
- MAX_BURST_LENGTH, 16, largest burst in words.
- LW, $clog2(MAX_BURST_LENGTH+1), width of each length field.
- GAP_WORDS, 2, idle words forced after every burst (0..15).
- IDLE_WORD, 8'b00000000, word driven whenever no burst is active.

Ports:
- clock  input  1  word clock (oserdes_pll word_clock_out). This is the only clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  connect to the PLL locked output. While low, no new grant is issued.
- request  input  NUM_REQUESTERS  level request, one bit per requester.
- request_length  input  NUM_REQUESTERS*LW  requested burst length, in words, per requester. Slice i is [i*LW +: LW].
- request_word  input  NUM_REQUESTERS*WIDTH  current word, per requester. Slice i is [i*WIDTH +: WIDTH].
- grant  output  NUM_REQUESTERS  one-hot owner of the current burst, registered.
- taken  output  NUM_REQUESTERS  one-hot. Bit i high means request_word slice i is consumed this cycle.
- word_out  output  WIDTH  registered word to the serializer D inputs, MSB first on the line.
- sync  output  1  high in the same cycle as the first word of each burst on word_out.
- busy  output  1  high in the SEND and GAP states.
- abort  output  1  one-cycle pulse when a burst is cut short.

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - word_out = IDLE_WORD.
  - If enable=1 and any request bit is high, pick a winner i round-robin. The search starts at ptr and wraps around. ptr resets to 0.
  - Latch len = max(request_length[i], 1), clamped to MAX_BURST_LENGTH.
  - Set grant=onehot(i) and ptr=(i+1) mod NUM_REQUESTERS, then go to SEND.
- SEND:
  - taken = grant (combinational: grant AND state==SEND).
  - word_out <= request_word[i] every cycle.
  - remaining counts down from len-1.
  - When remaining==0, clear grant and go to GAP. If GAP_WORDS==0, go to IDLE instead.
- Abort: if request[i] is low in a SEND cycle, that cycle's word is not taken (taken=0, word_out <= IDLE_WORD).
  - Pulse abort, clear grant, and go to GAP (or IDLE if GAP_WORDS==0).
  - Words already emitted stand.
- GAP: word_out = IDLE_WORD for exactly GAP_WORDS cycles, then go to IDLE.
- enable falling mid-burst does not abort the burst. The burst and its gap complete, and no new grant is issued afterwards until enable=1.
- A requester must hold request high for its whole burst. It advances request_word after each cycle in which its taken bit is high.
- request_length = 0 is treated as 1. A value above MAX_BURST_LENGTH is clamped.
- Reset values: grant=0, taken=0, word_out=IDLE_WORD, sync=0, busy=0, abort=0, state=IDLE, ptr=0, remaining=0.

## Timing
- Cycle t: IDLE sees request.
- Cycle t+1: grant and taken high, and the first word is sampled.
- Cycle t+2: the first word appears on word_out with sync=1.
- A burst of length L occupies word_out for cycles t+2..t+L+1.
- IDLE_WORD is then held for at least GAP_WORDS+1 cycles, which covers the gap plus one IDLE arbitration cycle. The next burst can therefore start on word_out no sooner than GAP_WORDS+1 words after the last word.
- Simultaneous requests are served in round-robin order from ptr. No requester waits longer than NUM_REQUESTERS-1 bursts.
- A request arriving during SEND or GAP waits and is arbitrated at the next IDLE cycle.
- Reset asserted at any time, including mid-burst: all outputs reach their reset values on the next clock edge, with no partial gap.

## Test plan
- Requester 0, length 4, words A1,A2,A3,A4; GAP_WORDS=2 -> word_out shows 00,A1..A4,00,00,00. taken[0] is high for 4 cycles and sync is high only with A1.
- Requesters 1 and 3 request together from reset -> 1 is served first, then 3. Then 1 and 3 request again -> 1 is served. This confirms the pointer wraps.
- Length 0 -> exactly one word is emitted. Length 31 with MAX=16 -> exactly 16 words.
- Requester 2 drops request after 2 of 5 words -> 2 words emitted, abort pulses once, then 2 IDLE_WORD gap cycles, grant=0.
- enable=0 with request=4'b1111 -> busy stays 0 and word_out stays 00. enable rises -> requester 0 is granted the next cycle.
- Reset for 1 cycle during the 3rd word of a burst -> the next cycle has grant=0, word_out=00, busy=0. The next burst goes to requester 0.
